// File: rtl/mcash_xbar_pkg.sv
// Shared crossbar/bank constants, opcodes and return-beat payload types.
package mcash_xbar_pkg;

  localparam int unsigned CH_NUM      = 3;
  localparam int unsigned CH_ID_W     = 2;
  localparam int unsigned ROB_NUM_W   = 3;
  localparam int unsigned DATA_W      = 128;
  localparam int unsigned ADDR_HI     = 31;
  localparam int unsigned ADDR_LO     = 4;
  localparam int unsigned ADDR_W      = ADDR_HI - ADDR_LO + 1;
  localparam int unsigned BANK_SEL_HI = 9;
  localparam int unsigned BANK_SEL_LO = 8;
  localparam int unsigned BANK_SEL_W  = BANK_SEL_HI - BANK_SEL_LO + 1;

  typedef enum logic [1:0] {
    REQ_READ   = 2'b00,
    REQ_WRITE  = 2'b01,
    REQ_ATOMIC = 2'b10,
    REQ_FLUSH  = 2'b11
  } req_op_e;

  // Per-channel stored entry; the channel id is implied by the buffer it lives in.
  typedef struct packed {
    logic [ROB_NUM_W-1:0] rob_num;
    logic [DATA_W-1:0]    data;
  } rtn_entry_t;

  typedef struct packed {
    logic [CH_ID_W-1:0] ch_id;
    rtn_entry_t         entry;
  } rtn_beat_t;

  // Bank select from a line address that starts at byte-address bit ADDR_LO.
  function automatic logic [BANK_SEL_W-1:0] bank_sel(input logic [ADDR_W-1:0] addr);
    return addr[BANK_SEL_HI-ADDR_LO -: BANK_SEL_W];
  endfunction

  // Channel id + 1, wrapping at n.
  function automatic logic [CH_ID_W-1:0] rr_inc(input logic [CH_ID_W-1:0] c,
                                                input int unsigned      n);
    if (32'(c) + 32'd1 >= n) return '0;
    return c + CH_ID_W'(1);
  endfunction

endpackage

// File: rtl/sc_rtn_ch_fifo.sv
// One channel's circular return buffer: write, send and free pointers with wrap bit.
module sc_rtn_ch_fifo
  import mcash_xbar_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       wr_en_i,
  input  rtn_entry_t wr_entry_i,
  input  logic       snd_en_i,
  input  logic       pop_i,
  output logic       full_c_o,
  output logic       unsent_nz_c_o,
  output logic       sent_nz_c_o,
  output rtn_entry_t head_c_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] snd_q, snd_d;
  logic [PW-1:0] fr_q, fr_d;
  logic [PW-1:0] occ;
  logic          do_wr;
  logic          do_snd;
  logic          do_pop;
  rtn_entry_t    mem_q [DEPTH];

  assign occ           = wr_q - fr_q;
  assign full_c_o      = (occ == PW'(DEPTH));
  assign unsent_nz_c_o = (wr_q != snd_q);
  assign sent_nz_c_o   = (snd_q != fr_q);
  assign head_c_o      = mem_q[snd_q[AW-1:0]];

  assign do_wr  = wr_en_i && !full_c_o;
  assign do_snd = snd_en_i && unsent_nz_c_o;
  assign do_pop = pop_i && sent_nz_c_o;

  // Each pointer moves at most one slot per cycle, independently of the others.
  always_comb begin
    wr_d  = wr_q;
    snd_d = snd_q;
    fr_d  = fr_q;
    if (do_wr)  wr_d  = wr_q + PW'(1);
    if (do_snd) snd_d = snd_q + PW'(1);
    if (do_pop) fr_d  = fr_q + PW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      snd_q <= '0;
      fr_q  <= '0;
    end else begin
      wr_q  <= wr_d;
      snd_q <= snd_d;
      fr_q  <= fr_d;
    end
  end

  // Storage needs no reset: pointers alone define which slots are live.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_q[AW-1:0]] <= wr_entry_i;
  end

endmodule

// File: rtl/bank_sc_rtn_buffer.sv
// Bank-side read-return staging: per-channel buffers, round-robin send, ROB-driven release.
module bank_sc_rtn_buffer
  import mcash_xbar_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CH_NUM = mcash_xbar_pkg::CH_NUM
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 pipe_rtn_valid_i,
  output logic                 pipe_rtn_allowIn_o,
  input  logic [CH_ID_W-1:0]   pipe_rtn_ch_id_i,
  input  logic [ROB_NUM_W-1:0] pipe_rtn_rob_num_i,
  input  logic [DATA_W-1:0]    pipe_rtn_data_i,
  output logic                 sc_xbar_valid_o,
  input  logic                 sc_xbar_allowIn_i,
  output logic [CH_ID_W-1:0]   sc_xbar_ch_id_o,
  output logic [ROB_NUM_W-1:0] sc_xbar_rob_num_o,
  output logic [DATA_W-1:0]    sc_xbar_data_o,
  input  logic [CH_NUM-1:0]    channel_spw_pop_i,
  output logic                 spw_err_o
);

  logic [CH_NUM-1:0]  full;
  logic [CH_NUM-1:0]  unsent_nz;
  logic [CH_NUM-1:0]  sent_nz;
  logic [CH_NUM-1:0]  wr_en;
  logic [CH_NUM-1:0]  snd_en;
  rtn_entry_t         head [CH_NUM];
  rtn_entry_t         in_entry;

  logic               ch_legal;
  logic               sel_full;
  logic               accept;
  logic               load;
  logic               gnt_vld;
  logic [CH_ID_W-1:0] gnt_ch;
  logic [CH_ID_W-1:0] cand;
  logic               pop_err;
  logic               ch_err;

  rtn_beat_t          out_q, out_d;
  logic               out_vld_q, out_vld_d;
  logic [CH_ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic               err_q, err_d;

  assign in_entry.rob_num = pipe_rtn_rob_num_i;
  assign in_entry.data    = pipe_rtn_data_i;

  // Input acceptance uses registered occupancy only; a same-cycle pop does not help.
  always_comb begin
    ch_legal = (32'(pipe_rtn_ch_id_i) < CH_NUM);
    sel_full = 1'b0;
    wr_en    = '0;
    for (int unsigned c = 0; c < CH_NUM; c++) begin
      if (pipe_rtn_ch_id_i == CH_ID_W'(c)) sel_full = full[c];
    end
    accept = pipe_rtn_valid_i && ch_legal && !sel_full;
    for (int unsigned c = 0; c < CH_NUM; c++) begin
      wr_en[c] = accept && (pipe_rtn_ch_id_i == CH_ID_W'(c));
    end
  end

  assign pipe_rtn_allowIn_o = ch_legal && !sel_full;

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    sc_rtn_ch_fifo #(
      .DEPTH(DEPTH)
    ) u_fifo (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .wr_en_i      (wr_en[g]),
      .wr_entry_i   (in_entry),
      .snd_en_i     (snd_en[g]),
      .pop_i        (channel_spw_pop_i[g]),
      .full_c_o     (full[g]),
      .unsent_nz_c_o(unsent_nz[g]),
      .sent_nz_c_o  (sent_nz[g]),
      .head_c_o     (head[g])
    );
  end

  // Round-robin search over channels with unsent entries, starting at rr_ptr.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_ch  = '0;
    cand    = '0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      cand = CH_ID_W'((32'(rr_ptr_q) + i) % CH_NUM);
      if (!gnt_vld && unsent_nz[cand]) begin
        gnt_vld = 1'b1;
        gnt_ch  = cand;
      end
    end
  end

  assign load = !out_vld_q || sc_xbar_allowIn_i;

  always_comb begin
    snd_en = '0;
    for (int unsigned c = 0; c < CH_NUM; c++) begin
      snd_en[c] = load && gnt_vld && (gnt_ch == CH_ID_W'(c));
    end
  end

  // Output register holds steady under backpressure and refills on accept or when empty.
  always_comb begin
    out_d     = out_q;
    out_vld_d = out_vld_q;
    rr_ptr_d  = rr_ptr_q;
    if (load) begin
      out_vld_d = gnt_vld;
      if (gnt_vld) begin
        out_d.ch_id = gnt_ch;
        out_d.entry = head[gnt_ch];
        rr_ptr_d    = rr_inc(gnt_ch, CH_NUM);
      end
    end
  end

  assign pop_err = |(channel_spw_pop_i & ~sent_nz);
  assign ch_err  = pipe_rtn_valid_i && !ch_legal;
  assign err_d   = err_q || pop_err || ch_err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_q     <= '0;
      out_vld_q <= 1'b0;
      rr_ptr_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
      rr_ptr_q  <= rr_ptr_d;
      err_q     <= err_d;
    end
  end

  assign sc_xbar_valid_o   = out_vld_q;
  assign sc_xbar_ch_id_o   = out_q.ch_id;
  assign sc_xbar_rob_num_o = out_q.entry.rob_num;
  assign sc_xbar_data_o    = out_q.entry.data;
  assign spw_err_o         = err_q;

endmodule

// File: tb/tb_bank_sc_rtn_buffer.sv
// Directed self-checking bench for bank_sc_rtn_buffer.
module tb_bank_sc_rtn_buffer;

  logic         clk;
  logic         rst;
  logic         pv;
  logic         pallow;
  logic [1:0]   pch;
  logic [2:0]   prob;
  logic [127:0] pdata;
  logic         xv;
  logic         xa;
  logic [1:0]   xch;
  logic [2:0]   xrob;
  logic [127:0] xdata;
  logic [2:0]   pop;
  logic         err;

  int n_assert = 0;
  int n_fail   = 0;

  bank_sc_rtn_buffer #(.DEPTH(4), .CH_NUM(3)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .pipe_rtn_valid_i  (pv),
    .pipe_rtn_allowIn_o(pallow),
    .pipe_rtn_ch_id_i  (pch),
    .pipe_rtn_rob_num_i(prob),
    .pipe_rtn_data_i   (pdata),
    .sc_xbar_valid_o   (xv),
    .sc_xbar_allowIn_i (xa),
    .sc_xbar_ch_id_o   (xch),
    .sc_xbar_rob_num_o (xrob),
    .sc_xbar_data_o    (xdata),
    .channel_spw_pop_i (pop),
    .spw_err_o         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [1:0] ch, input logic [2:0] rob, input logic [127:0] d);
    pv    = 1'b1;
    pch   = ch;
    prob  = rob;
    pdata = d;
  endtask

  function automatic logic [127:0] dpat(input int k);
    return {4{32'hC0DE_0000 + 32'(k)}};
  endfunction

  int unsigned exp_ch  [5] = '{1, 2, 0, 1, 2};
  int unsigned exp_rob [5] = '{2, 4, 1, 3, 5};

  initial begin
    rst = 1'b1; pv = 1'b0; pch = '0; prob = '0; pdata = '0; xa = 1'b1; pop = '0;
    #2;
    check("rst_valid", 128'(xv), 128'(0));
    check("rst_err", 128'(err), 128'(0));
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_ch", 128'(xch), 128'(0));
    check("rst_rob", 128'(xrob), 128'(0));
    check("rst_data", xdata, 128'(0));
    check("rst_allow", 128'(pallow), 128'(1));

    // Single beat: ch1, rob 5, 0xA5 data; visible two cycles after handshake.
    put(2'd1, 3'd5, {16{8'hA5}});
    #1 check("t1_allow", 128'(pallow), 128'(1));
    tick();
    pv = 1'b0;
    check("t1_not_yet", 128'(xv), 128'(0));
    tick();
    check("t1_valid", 128'(xv), 128'(1));
    check("t1_ch", 128'(xch), 128'(1));
    check("t1_rob", 128'(xrob), 128'(5));
    check("t1_data", xdata, {16{8'hA5}});
    pop = 3'b010;
    tick();
    pop = 3'b000;
    check("t1_drained", 128'(xv), 128'(0));
    check("t1_pop_ok", 128'(err), 128'(0));

    // Fill channel 0 with four unreleased beats.
    for (int i = 0; i < 4; i++) begin
      put(2'd0, 3'(i), 128'(i + 1));
      #1 check("t2_fill_allow", 128'(pallow), 128'(1));
      tick();
    end
    pv = 1'b0; pch = 2'd0;
    #1 check("t2_full_ch0", 128'(pallow), 128'(0));
    pch = 2'd2;
    #1 check("t2_ch2_open", 128'(pallow), 128'(1));
    pch = 2'd0; pop = 3'b001;
    #1 check("t2_no_bypass", 128'(pallow), 128'(0));
    tick();
    pop = 3'b000;
    #1 check("t2_released", 128'(pallow), 128'(1));
    pop = 3'b001;
    tick(); tick(); tick();
    pop = 3'b000;
    check("t2_err", 128'(err), 128'(0));
    check("t2_idle", 128'(xv), 128'(0));

    // Backpressure and round-robin: two beats each on ch0, ch1, ch2.
    xa = 1'b0;
    for (int k = 0; k < 6; k++) begin
      put(2'(k / 2), 3'(k), dpat(k));
      tick();
      if (k >= 1) begin
        check("t3_hold_valid", 128'(xv), 128'(1));
        check("t3_hold_ch", 128'(xch), 128'(0));
        check("t3_hold_rob", 128'(xrob), 128'(0));
        check("t3_hold_data", xdata, dpat(0));
      end
    end
    pv = 1'b0;
    tick();
    check("t3_hold_last", xdata, dpat(0));
    xa = 1'b1;
    for (int j = 0; j < 5; j++) begin
      tick();
      check("t3_rr_valid", 128'(xv), 128'(1));
      check("t3_rr_ch", 128'(xch), 128'(exp_ch[j]));
      check("t3_rr_rob", 128'(xrob), 128'(exp_rob[j]));
      check("t3_rr_data", xdata, dpat(int'(exp_rob[j])));
    end
    tick();
    check("t3_rr_done", 128'(xv), 128'(0));
    pop = 3'b111;
    tick(); tick();
    pop = 3'b000;
    check("t3_pop_ok", 128'(err), 128'(0));

    // Spurious pop on ch2 flags an error and leaves ch2 pointers alone.
    pop = 3'b100;
    tick();
    pop = 3'b000;
    check("t4_pop_err", 128'(err), 128'(1));
    pch = 2'd2;
    #1 check("t4_ch2_allow", 128'(pallow), 128'(1));
    put(2'd2, 3'd7, dpat(9));
    tick();
    pv = 1'b0;
    tick();
    check("t4_ch2_valid", 128'(xv), 128'(1));
    check("t4_ch2_rob", 128'(xrob), 128'(7));
    check("t4_ch2_data", xdata, dpat(9));
    tick();
    pop = 3'b100;
    tick();
    pop = 3'b000;
    check("t4_sticky", 128'(err), 128'(1));

    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_err_clr", 128'(err), 128'(0));

    // Illegal channel id is refused and flagged.
    put(2'd3, 3'd1, dpat(3));
    #1 check("t4_ill_allow", 128'(pallow), 128'(0));
    tick();
    pv = 1'b0;
    check("t4_ill_err", 128'(err), 128'(1));
    tick(); tick();
    check("t4_ill_noout", 128'(xv), 128'(0));

    // Reset mid-stream with three beats buffered.
    xa = 1'b0;
    for (int k = 0; k < 3; k++) begin
      put(2'd0, 3'(k), dpat(20 + k));
      tick();
    end
    pv = 1'b0;
    check("t5_pre_valid", 128'(xv), 128'(1));
    #3 rst = 1'b1;
    #1;
    check("t5_async_valid", 128'(xv), 128'(0));
    check("t5_async_err", 128'(err), 128'(0));
    tick();
    rst = 1'b0;
    xa = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t5_no_beat", 128'(xv), 128'(0));
    end
    pch = 2'd0;
    #1 check("t5_allow", 128'(pallow), 128'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
